// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Owns the single write port of the 32x32 MIPS register file. After reset it
// clears every register through that port, one register per cycle. It then
// shares the port between two writeback requesters (A: pipeline writeback,
// B: multicycle/load unit) using valid/ready handshakes and round-robin
// arbitration. The outputs drive RegWrite/Write_reg/Write_data directly.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   a_valid     requester A has a write pending
//   a_ready     A's request is accepted this cycle
//   a_addr      A's destination register
//   a_data      A's write data
//   b_valid     requester B has a write pending
//   b_ready     B's request is accepted this cycle
//   b_addr      B's destination register
//   b_data      B's write data
//   RegWrite    register-file write enable (registered)
//   Write_reg   register-file write address (registered)
//   Write_data  register-file write data (registered)
//   init_done   high once the init clear has completed (registered)
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int                NUM_REGS   = 32,
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    output logic              init_done
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_next;
    grant_t            last_grant;
    logic [ADDR_W-1:0] cnt;
    logic              a_xfer, b_xfer;

    // ---------------------------------------------------------------- readies
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == RUN) begin
            if (a_valid && b_valid) begin
                // Round-robin: the requester that did not win last goes now.
                if (last_grant == GRANT_B) a_ready = 1'b1;
                else                       b_ready = 1'b1;
            end else if (a_valid) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    // ------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        if (state == INIT && cnt == LAST_REG) state_next = RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_next;
    end

    // --------------------------------------------------- write port + counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            RegWrite   <= 1'b0;
            Write_reg  <= '0;
            Write_data <= '0;
            init_done  <= 1'b0;
            last_grant <= GRANT_B;
        end else begin
            case (state)
                INIT: begin
                    RegWrite   <= 1'b1;
                    Write_reg  <= cnt;
                    Write_data <= INIT_VALUE;
                    cnt        <= cnt + ADDR_W'(1);
                    if (cnt == LAST_REG) init_done <= 1'b1;
                end
                RUN: begin
                    // Default: no write this cycle; address and data hold.
                    RegWrite <= 1'b0;
                    if (a_xfer) begin
                        last_grant <= GRANT_A;
                        // Register 0 is hardwired: the handshake completes
                        // but nothing is written to the register file.
                        if (a_addr != '0) begin
                            RegWrite   <= 1'b1;
                            Write_reg  <= a_addr;
                            Write_data <= a_data;
                        end
                    end else if (b_xfer) begin
                        last_grant <= GRANT_B;
                        if (b_addr != '0) begin
                            RegWrite   <= 1'b1;
                            Write_reg  <= b_addr;
                            Write_data <= b_data;
                        end
                    end
                end
                default: RegWrite <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Bench for regfile_wr_arbiter. Keeps a shadow register file fed from the
// DUT's write port, walks the init clear, applies a table of directed RUN
// vectors, exercises reset during a pending write, and finishes with a
// randomized phase scored against a request-level arbitration model.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  Write_reg;
    logic [31:0] Write_data;
    logic        init_done;

    regfile_wr_arbiter #(
        .NUM_REGS  (32),
        .ADDR_W    (5),
        .DATA_W    (32),
        .INIT_VALUE(32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .RegWrite  (RegWrite),
        .Write_reg (Write_reg),
        .Write_data(Write_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow register file driven by the DUT's write port.
    logic [31:0] mem [32];
    always @(posedge clk) if (RegWrite) mem[Write_reg] <= Write_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Walk the 32-cycle clear; requesters must be held off throughout.
    task automatic run_init();
        check("init_done_before_clear", init_done, 0);
        for (int i = 0; i < 32; i++) begin
            check("init_a_ready", a_ready, 0);
            check("init_b_ready", b_ready, 0);
            @(posedge clk); #1;
            check("init_we",   RegWrite,   1);
            check("init_reg",  Write_reg,  i[4:0]);
            check("init_data", Write_data, 0);
            check("init_done", init_done,  (i == 31) ? 1 : 0);
        end
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
        logic        ewe;
        logic        chk;    // compare Write_reg/Write_data after the edge
        logic [4:0]  ereg;
        logic [31:0] edata;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ea, input logic eb, input logic ewe, input logic chk,
                                input logic [4:0] ereg, input logic [31:0] edata);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.ea = ea; v.eb = eb; v.ewe = ewe; v.chk = chk;
        v.ereg = ereg; v.edata = edata;
        return v;
    endfunction

    vec_t vecs[15];

    // Random-phase model state: one pending request per requester.
    logic        pa, pb;
    logic [4:0]  paa, pba;
    logic [31:0] pad, pbd;
    logic        lg_b;
    logic [31:0] exp_mem [32];

    initial begin
        int zeros;
        logic        ga, gb, exp_we;
        logic [4:0]  w_addr;
        logic [31:0] w_data;

        // Directed RUN vectors. Starts with last grant = A (A wins the
        // post-init transfer of reg 5).
        //                A: v  addr  data        B: v  addr  data        rdyA rdyB we chk reg  data
        vecs[0]  = mk(0, 5'd0, 32'h0,      1, 5'd8, 32'h88,     0, 1, 1, 1, 5'd8, 32'h88);
        vecs[1]  = mk(1, 5'd3, 32'hAAAA,   1, 5'd4, 32'hBBBB,   1, 0, 1, 1, 5'd3, 32'hAAAA);
        vecs[2]  = mk(1, 5'd3, 32'hAAAA,   1, 5'd4, 32'hBBBB,   0, 1, 1, 1, 5'd4, 32'hBBBB);
        vecs[3]  = mk(1, 5'd3, 32'hAAAA,   1, 5'd4, 32'hBBBB,   1, 0, 1, 1, 5'd3, 32'hAAAA);
        vecs[4]  = mk(1, 5'd3, 32'hAAAA,   1, 5'd4, 32'hBBBB,   0, 1, 1, 1, 5'd4, 32'hBBBB);
        vecs[5]  = mk(0, 5'd0, 32'h0,      0, 5'd0, 32'h0,      0, 0, 0, 1, 5'd4, 32'hBBBB);
        vecs[6]  = mk(0, 5'd0, 32'h0,      1, 5'd0, 32'hDEAD,   0, 1, 0, 0, 5'd0, 32'h0);
        vecs[7]  = mk(0, 5'd0, 32'h0,      1, 5'd1, 32'h2,      0, 1, 1, 1, 5'd1, 32'h2);
        vecs[8]  = mk(1, 5'd10, 32'h55,    0, 5'd0, 32'h0,      1, 0, 1, 1, 5'd10, 32'h55);
        vecs[9]  = mk(1, 5'd7, 32'h11,     1, 5'd7, 32'h22,     0, 1, 1, 1, 5'd7, 32'h22);
        vecs[10] = mk(1, 5'd7, 32'h11,     0, 5'd0, 32'h0,      1, 0, 1, 1, 5'd7, 32'h11);
        vecs[11] = mk(0, 5'd0, 32'h0,      0, 5'd0, 32'h0,      0, 0, 0, 1, 5'd7, 32'h11);
        vecs[12] = mk(1, 5'd0, 32'hBEEF,   0, 5'd0, 32'h0,      1, 0, 0, 0, 5'd0, 32'h0);
        vecs[13] = mk(1, 5'd2, 32'h21,     1, 5'd6, 32'h61,     0, 1, 1, 1, 5'd6, 32'h61);
        vecs[14] = mk(1, 5'd2, 32'h21,     0, 5'd0, 32'h0,      1, 0, 1, 1, 5'd2, 32'h21);

        // ---------------- reset state, A held from reset through init
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
        #2;
        check("rst_we",        RegWrite,   0);
        check("rst_reg",       Write_reg,  0);
        check("rst_data",      Write_data, 0);
        check("rst_init_done", init_done,  0);
        check("rst_a_ready",   a_ready,    0);
        check("rst_b_ready",   b_ready,    0);
        #8 rst = 1'b1;   // release at t=10 ns
        run_init();

        check("run_first_a_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("held_a_we",   RegWrite,   1);
        check("held_a_reg",  Write_reg,  5);
        check("held_a_data", Write_data, 1);
        @(posedge clk); #1;
        check("held_a_we_drop", RegWrite, 0);
        check("held_a_mem5",    mem[5],   1);
        zeros = 0;
        for (int i = 0; i < 32; i++) if (i != 5 && mem[i] == 32'h0) zeros++;
        check("init_clear_count", zeros, 31);

        // ---------------- directed RUN table
        for (int i = 0; i < 15; i++) begin
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            #1;
            check($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].ea);
            check($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].eb);
            @(posedge clk); #1;
            check($sformatf("vec%0d_we", i), RegWrite, vecs[i].ewe);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_reg", i),  Write_reg,  vecs[i].ereg);
                check($sformatf("vec%0d_data", i), Write_data, vecs[i].edata);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        check("table_idle_we", RegWrite, 0);
        check("mem7_collision", mem[7], 32'h11);
        check("mem4",           mem[4], 32'hBBBB);
        check("mem2",           mem[2], 32'h21);
        check("mem1",           mem[1], 32'h2);
        check("mem0_hardwired", mem[0], 32'h0);

        // ---------------- reset while a write to reg 9 is pending
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234;
        #1;
        check("rst9_a_ready", a_ready, 1);
        @(posedge clk); #1;
        check("rst9_we_pending", RegWrite,  1);
        check("rst9_reg",        Write_reg, 9);
        a_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst9_we_squashed", RegWrite,  0);
        check("rst9_init_done",   init_done, 0);
        @(posedge clk); #1;
        check("rst9_mem9", mem[9], 0);
        @(negedge clk);
        rst = 1'b1;
        run_init();
        @(posedge clk); #1;
        check("init2_we_after", RegWrite,  0);
        check("init2_done_hold", init_done, 1);
        zeros = 0;
        for (int i = 0; i < 32; i++) if (mem[i] == 32'h0) zeros++;
        check("init2_clear_count", zeros, 32);

        // ---------------- randomized phase vs. request-level model
        pa = 1'b0; pb = 1'b0; paa = '0; pba = '0; pad = '0; pbd = '0;
        lg_b = 1'b1;
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; paa = 5'($urandom_range(0, 15)); pad = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; pba = 5'($urandom_range(0, 15)); pbd = $urandom;
            end
            a_valid = pa; a_addr = paa; a_data = pad;
            b_valid = pb; b_addr = pba; b_data = pbd;
            #1;
            ga = pa && (!pb || lg_b);
            gb = pb && !ga;
            check("rnd_a_ready", a_ready, ga);
            check("rnd_b_ready", b_ready, gb);
            @(posedge clk); #1;
            w_addr = '0; w_data = '0;
            if (ga) begin
                w_addr = paa; w_data = pad; pa = 1'b0; lg_b = 1'b0;
            end else if (gb) begin
                w_addr = pba; w_data = pbd; pb = 1'b0; lg_b = 1'b1;
            end
            exp_we = (ga || gb) && (w_addr != 5'd0);
            check("rnd_we", RegWrite, exp_we);
            if (exp_we) begin
                check("rnd_reg",  Write_reg,  w_addr);
                check("rnd_data", Write_data, w_data);
                exp_mem[w_addr] = w_data;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++)
            check($sformatf("rnd_mem%0d", i), mem[i], exp_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
